// File: rtl/seqdet_ctrl.sv
// Programmable bit-serial sequence detector: arm, fill, match overlapping
// occurrences, finish on match target or window timeout, hold status until ack.
module seqdet_ctrl #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 8,
  parameter int WIN_W   = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic [MAX_LEN-1:0] pattern_i,
  input  logic [LEN_W-1:0]   pat_len_i,
  input  logic [CNT_W-1:0]   target_i,
  input  logic [WIN_W-1:0]   window_i,
  input  logic               inp_i,
  input  logic               inp_valid_i,
  input  logic               ack_i,
  output logic               busy_o,
  output logic               det_o,
  output logic [CNT_W-1:0]   match_cnt_o,
  output logic               done_o,
  output logic               timeout_o
);

  typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_e;

  state_e             state_q, state_d;
  logic [MAX_LEN-1:0] sr_q, sr_d, pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d, fill_q, fill_d;
  logic [CNT_W-1:0]   tgt_q, tgt_d, cnt_q, cnt_d;
  logic [WIN_W-1:0]   win_q, win_d, timer_q, timer_d;
  logic               det_q, det_d, done_q, done_d, tmo_q, tmo_d;

  logic [MAX_LEN-1:0] sr_shift, mask;
  logic [LEN_W-1:0]   fill_inc;
  logic [CNT_W-1:0]   cnt_inc;
  logic               hit, win_exp, armed, match_now, reach;

  always_comb begin
    sr_shift = {sr_q[MAX_LEN-2:0], inp_i};
    for (int i = 0; i < MAX_LEN; i++) mask[i] = (i < int'(len_q));
    hit      = (((sr_shift ^ pat_q) & mask) == '0);
    fill_inc = fill_q + 1'b1;
    cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    win_exp  = (win_q != '0) && (timer_q == win_q - 1'b1);
    // The bit that completes the fill is already eligible to match.
    armed     = (state_q == RUN) || (fill_inc == len_q);
    match_now = inp_valid_i && armed && hit;
    reach     = match_now && (cnt_inc >= tgt_q);
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    pat_d   = pat_q;
    len_d   = len_q;
    fill_d  = fill_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    win_d   = win_q;
    timer_d = timer_q;
    det_d   = 1'b0;
    done_d  = done_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      IDLE: if (start_i) begin
        pat_d   = pattern_i;
        len_d   = (pat_len_i == '0) ? LEN_W'(1) :
                  (pat_len_i > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : pat_len_i;
        tgt_d   = (target_i == '0) ? CNT_W'(1) : target_i;
        win_d   = window_i;
        sr_d    = '0;
        fill_d  = '0;
        timer_d = '0;
        cnt_d   = '0;
        tmo_d   = 1'b0;
        state_d = FILL;
      end
      FILL, RUN: begin
        timer_d = timer_q + 1'b1;
        if (inp_valid_i) sr_d = sr_shift;
        if (abort_i) begin
          state_d = IDLE;
        end else begin
          if (state_q == FILL && inp_valid_i) begin
            fill_d = fill_inc;
            if (fill_inc == len_q) state_d = RUN;
          end
          if (match_now) begin
            det_d = 1'b1;
            cnt_d = cnt_inc;
          end
          // A target-reaching match on the expiry edge is reported as success.
          if (reach) begin
            state_d = DONE;
            done_d  = 1'b1;
            tmo_d   = 1'b0;
          end else if (win_exp) begin
            state_d = DONE;
            done_d  = 1'b1;
            tmo_d   = 1'b1;
          end
        end
      end
      DONE: if (ack_i) begin
        state_d = IDLE;
        done_d  = 1'b0;
        tmo_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      sr_q    <= '0;
      pat_q   <= '0;
      len_q   <= '0;
      fill_q  <= '0;
      tgt_q   <= '0;
      cnt_q   <= '0;
      win_q   <= '0;
      timer_q <= '0;
      det_q   <= 1'b0;
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      fill_q  <= fill_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      win_q   <= win_d;
      timer_q <= timer_d;
      det_q   <= det_d;
      done_q  <= done_d;
      tmo_q   <= tmo_d;
    end
  end

  assign busy_o      = (state_q != IDLE);
  assign det_o       = det_q;
  assign match_cnt_o = cnt_q;
  assign done_o      = done_q;
  assign timeout_o   = tmo_q;

endmodule

// File: tb/tb_seqdet_ctrl.sv
// Directed bench for seqdet_ctrl with hand-computed expectations.
module tb_seqdet_ctrl;
  logic       clk = 1'b0;
  logic       rst_n, start, abort, inp, vld, ack;
  logic [7:0] pattern, target;
  logic [3:0] pat_len;
  logic [15:0] window;
  logic       busy, det, done, tmo;
  logic [7:0] cnt;
  int         n_vec = 0, n_err = 0;

  seqdet_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
    .pattern_i(pattern), .pat_len_i(pat_len), .target_i(target),
    .window_i(window), .inp_i(inp), .inp_valid_i(vld), .ack_i(ack),
    .busy_o(busy), .det_o(det), .match_cnt_o(cnt), .done_o(done),
    .timeout_o(tmo)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] p, input logic [3:0] l,
                          input logic [7:0] t, input logic [15:0] w);
    pattern = p; pat_len = l; target = t; window = w; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  // Sends n bits MSB-first with valid high, checking det after each edge.
  task automatic run_bits(input string tag, input logic [15:0] bits,
                          input logic [15:0] exp, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      inp = bits[i]; vld = 1'b1;
      tick();
      chk($sformatf("%s det%0d", tag, n - i), {31'd0, det}, {31'd0, exp[i]});
    end
    vld = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 0; abort = 0; inp = 0; vld = 0; ack = 0;
    pattern = '0; pat_len = '0; target = '0; window = '0;
    tick(); tick();
    chk("rst busy", busy, 0); chk("rst done", done, 0);
    chk("rst cnt", cnt, 0);   chk("rst det", det, 0); chk("rst tmo", tmo, 0);
    rst_n = 1'b1;
    tick();

    // Basic: 001, len 3, target 2, no window
    do_start(8'b001, 4'd3, 8'd2, 16'd0);
    chk("t1 busy", busy, 1);
    run_bits("t1", 16'b001001, 16'b001001, 6);
    chk("t1 cnt", cnt, 2); chk("t1 done", done, 1); chk("t1 tmo", tmo, 0);
    tick();
    chk("t1 det off", det, 0); chk("t1 done hold", done, 1);
    do_ack();
    chk("t1 ack busy", busy, 0); chk("t1 ack done", done, 0); chk("t1 cnt hold", cnt, 2);

    // Overlap: 1010 x3, started the cycle right after ack
    do_start(8'b1010, 4'd4, 8'd3, 16'd0);
    chk("t2 busy", busy, 1); chk("t2 cnt clr", cnt, 0);
    run_bits("t2", 16'b10101010, 16'b00010101, 8);
    chk("t2 cnt", cnt, 3); chk("t2 done", done, 1);
    do_start(8'b1, 4'd1, 8'd1, 16'd5);
    chk("t2 start ign done", done, 1); chk("t2 start ign cnt", cnt, 3);
    do_ack();

    // Valid gaps: 0 _ 0 _ _ 1
    do_start(8'b001, 4'd3, 8'd1, 16'd0);
    run_bits("t3a", 16'b0, 16'b0, 1);
    tick(); chk("t3 gap1 det", det, 0);
    run_bits("t3b", 16'b0, 16'b0, 1);
    tick(); tick(); chk("t3 gap2 det", det, 0);
    run_bits("t3c", 16'b1, 16'b1, 1);
    chk("t3 done", done, 1); chk("t3 cnt", cnt, 1);
    do_ack();

    // Timeout: window 10, all ones
    do_start(8'b001, 4'd3, 8'd1, 16'd10);
    run_bits("t4a", 16'h1FF, 16'h0, 9);
    chk("t4 done early", done, 0);
    run_bits("t4b", 16'b1, 16'b0, 1);
    chk("t4 done", done, 1); chk("t4 tmo", tmo, 1); chk("t4 cnt", cnt, 0);
    do_ack();
    chk("t4 ack tmo", tmo, 0);

    // Match wins on the expiry edge
    do_start(8'b001, 4'd3, 8'd1, 16'd10);
    run_bits("t5a", 16'b111111100, 16'h0, 9);
    chk("t5 done early", done, 0);
    run_bits("t5b", 16'b1, 16'b1, 1);
    chk("t5 done", done, 1); chk("t5 tmo", tmo, 0); chk("t5 cnt", cnt, 1);
    do_ack();

    // Abort after 2 of 3 matches; abort edge carries a would-be match
    do_start(8'b001, 4'd3, 8'd3, 16'd0);
    run_bits("t6", 16'b00100100, 16'b00100100, 8);
    inp = 1'b1; vld = 1'b1; abort = 1'b1;
    tick();
    abort = 1'b0; vld = 1'b0;
    chk("t6 det", det, 0); chk("t6 busy", busy, 0);
    chk("t6 done", done, 0); chk("t6 cnt", cnt, 2);

    // Reset mid-run with a pending match
    do_start(8'b001, 4'd3, 8'd3, 16'd0);
    run_bits("t7", 16'b00100, 16'b00100, 5);
    inp = 1'b1; vld = 1'b1; rst_n = 1'b0;
    tick();
    vld = 1'b0; rst_n = 1'b1;
    chk("t7 det", det, 0); chk("t7 busy", busy, 0); chk("t7 cnt", cnt, 0);
    chk("t7 done", done, 0);

    // Clamp pat_len=0 -> 1
    do_start(8'b1, 4'd0, 8'd3, 16'd0);
    run_bits("t8", 16'b1011, 16'b1011, 4);
    chk("t8 done", done, 1); chk("t8 cnt", cnt, 3);
    do_ack();

    // Clamp pat_len=12 -> 8
    do_start(8'b11001010, 4'd12, 8'd1, 16'd0);
    run_bits("t9", 16'b11001010, 16'b00000001, 8);
    chk("t9 done", done, 1);
    do_ack();

    // Clamp target=0 -> 1
    do_start(8'b1, 4'd1, 8'd0, 16'd0);
    run_bits("t10", 16'b1, 16'b1, 1);
    chk("t10 done", done, 1); chk("t10 cnt", cnt, 1);
    do_ack();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/seqdet_ctrl.md
# seqdet_ctrl

Programmable bit-serial sequence-detection controller. Arms on a start command, loads a pattern of 1–MAX_LEN bits, watches a qualified serial input for overlapping occurrences, pulses det per match, and finishes after a target match count or a cycle-window timeout. It sits between a configuration/host interface and the serial-input datapath of the sequence detectors. Status is held until the host acknowledges it.

## Interface
- MAX_LEN, 8: maximum pattern length in bits (≥2).
- LEN_W, 4: width of pat_len; must hold MAX_LEN.
- CNT_W, 8: width of the match target and match counter.
- WIN_W, 16: width of the timeout window.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  pulse; arms a run (honoured only in IDLE).
- abort  in  1  cancels an active run (FILL/RUN) without raising done.
- pattern  in  MAX_LEN  pattern; bit pat_len-1 is the first-received bit, bit 0 the last.
- pat_len  in  LEN_W  pattern length.
- target  in  CNT_W  matches required to finish.
- window  in  WIN_W  timeout in cycles; 0 disables the timeout.
- inp  in  1  serial data bit.
- inp_valid  in  1  qualifies inp; no shift when low.
- ack  in  1  clears done (honoured only in DONE).
- busy  out  1  high in FILL, RUN and DONE.
- det  out  1  one-cycle pulse per match.
- match_cnt  out  CNT_W  matches in the current or last run.
- done  out  1  run finished; held until ack.
- timeout  out  1  valid with done; 1 means the window expired.

## Operation
- Reset (rst=0 at an edge): state IDLE. busy, det, done, timeout and match_cnt are 0. Shift register, fill counter and timer are cleared. Reset overrides every other input.
- States: IDLE, FILL, RUN, DONE.
- IDLE, when start=1:
  - Latch pattern, pat_len, target and window.
  - Clamp the lengths: pat_len=0 becomes 1; pat_len>MAX_LEN becomes MAX_LEN; target=0 becomes 1.
  - Clear the shift register, fill counter, timer, match_cnt and timeout. Go to FILL.
- Shift register update: on every edge in FILL/RUN with inp_valid=1, sr <= {sr[MAX_LEN-2:0], inp}.
- FILL:
  - Each valid bit increments the fill counter.
  - When the incoming valid bit brings the count to len, go to RUN. That same bit is also tested for a match.
- Match test (FILL completing, or RUN): with inp_valid=1, a match occurs when the new sr[len-1:0] equals pattern[len-1:0].
  - Overlapping matches count; the shift register is never cleared after a match.
  - On a match: det=1 for the next cycle and match_cnt+1.
  - When match_cnt reaches the target, go to DONE with timeout=0.
- Timer:
  - Increments on every edge in FILL/RUN, whether or not inp_valid is high.
  - If window≠0 and timer==window-1 at an edge, go to DONE with timeout=1.
  - If the target-reaching match lands on that same edge, the match wins: DONE with timeout=0, det still pulses.
- abort in FILL/RUN: go to IDLE. done stays 0 and match_cnt holds. A match on the abort edge is discarded (no det). abort has priority over match and timeout.
- DONE:
  - done=1 and busy=1. Inputs are not shifted and start is ignored.
  - ack=1 → IDLE; done, busy and timeout go to 0 the next cycle.
  - match_cnt holds until the next start.
- start outside IDLE and ack outside DONE have no effect.
- match_cnt saturates at all-ones. It cannot exceed target, because the block leaves RUN when target is reached.

## Timing
- All outputs are registered.
- start sampled at edge 0 → busy=1 from cycle 1.
- inp sampled at edge k produces a match → det=1 during cycle k+1 only. match_cnt shows the new value in cycle k+1.
- The final match: det, match_cnt update and done all rise in the same cycle, k+1.
- Timeout: done rises exactly window cycles after busy rises.
- Minimum turnaround: ack at edge a → IDLE in cycle a+1; a start at edge a+1 is accepted.
- Back-to-back valid bits may match on consecutive cycles, giving det high for consecutive cycles. Each cycle is a distinct match.

## Test plan
- Pattern 001, len 3, target 2, window 0; stream 0,0,1,0,0,1 with valid continuous → det after bits 3 and 6; match_cnt=2; done=1 with det in the cycle after bit 6; timeout=0.
- Overlap: pattern 1010, len 4, target 3; stream 1,0,1,0,1,0,1,0 → det after bits 4, 6 and 8; match_cnt=3; done=1.
- Valid gaps: pattern 001, target 1; bits 0,_,0,_,_,1 with inp_valid low in the gaps → exactly one det, one cycle after the last valid bit.
- Timeout: window 10, stream all 1s, pattern 001 → done=1 and timeout=1, 10 cycles after busy rose; match_cnt=0. Repeat with the target-reaching match on the window-1 edge → timeout=0.
- Abort and reset mid-run:
  - abort after 2 of 3 target matches → IDLE, done=0, match_cnt=2.
  - rst=0 in RUN → all outputs 0 at the next cycle.
  - start, then ack, start again → the new run begins with match_cnt=0.
- Clamping: pat_len=0 with pattern bit 0 = 1 → det on every valid 1. pat_len=12 → behaves as len 8. target=0 → done after the first match.
